// File: rtl/ppu_dot_sampler.sv
// ppu_dot_sampler: samples the PPU pixel stream per dot and tracks dot position.
// Output is blanked to black until the position counters are locked to frame_start.
module ppu_dot_sampler #(
    parameter int unsigned H_TOTAL     = 341,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter logic [5:0]  BLACK_COLOR = 6'h0F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_dot,
    input  logic [5:0] ppu_color,
    input  logic       greyscale,
    input  logic [2:0] ppu_emphasis,
    input  logic       frame_start,
    input  logic       dot_skip,
    output logic [5:0] color,
    output logic [2:0] emphasis,
    output logic [8:0] count_h,
    output logic [8:0] count_v,
    output logic       pix_valid,
    output logic       locked,
    output logic       frame_done,
    output logic [7:0] resync_count
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_SKIP   = 9'(H_TOTAL - 2);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] good_cnt;
    logic [3:0] good_nxt;
    logic       resync_inc;

    logic [8:0] pos_h;
    logic [8:0] pos_v;
    logic [8:0] nxt_h;
    logic [8:0] nxt_v;

    logic       at_origin;
    logic       at_skip;
    logic       at_last;
    logic       skip_take;
    logic       last_dot;

    logic [8:0] smp_h;
    logic [8:0] smp_v;
    logic       lock_now;
    logic [5:0] dat_color;
    logic [2:0] dat_emph;

    assign at_origin = (pos_h == 9'd0) && (pos_v == 9'd0);
    assign at_skip   = (pos_h == H_SKIP) && (pos_v == V_LAST);
    assign at_last   = (pos_h == H_LAST) && (pos_v == V_LAST);
    // frame_start beats dot_skip: a forced dot is (0,0), never a frame end
    assign skip_take = dot_skip && at_skip && !frame_start;
    assign last_dot  = !frame_start && (at_last || skip_take);

    // Position of the dot after this one: realign, odd-frame skip, or advance
    always_comb begin
        nxt_h = pos_h;
        nxt_v = pos_v;
        if (frame_start) begin
            nxt_h = 9'd1;
            nxt_v = 9'd0;
        end else if (skip_take) begin
            nxt_h = 9'd0;
            nxt_v = 9'd0;
        end else if (pos_h == H_LAST) begin
            nxt_h = 9'd0;
            nxt_v = (pos_v == V_LAST) ? 9'd0 : pos_v + 9'd1;
        end else begin
            nxt_h = pos_h + 9'd1;
        end
    end

    // Position counters move one dot per ce_dot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_h <= 9'd0;
            pos_v <= 9'd0;
        end else if (ce_dot) begin
            pos_h <= nxt_h;
            pos_v <= nxt_v;
        end
    end

    // Lock state and matching-frame counter, stepped per dot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_UNLOCKED;
            good_cnt <= 4'd0;
        end else if (ce_dot) begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Lock acquisition: frame_start must keep landing on our own (0,0)
    always_comb begin
        state_nxt  = state;
        good_nxt   = good_cnt;
        resync_inc = 1'b0;
        unique case (state)
            ST_UNLOCKED: begin
                if (frame_start) begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = 4'd0;
                end
            end
            ST_ACQUIRE: begin
                if (frame_start && at_origin) begin
                    good_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LOCK_TGT) begin
                        state_nxt = ST_LOCKED;
                    end
                end else if (frame_start || at_origin) begin
                    good_nxt = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (frame_start != at_origin) begin
                    state_nxt  = ST_ACQUIRE;
                    good_nxt   = 4'd0;
                    resync_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_UNLOCKED;
                good_nxt  = 4'd0;
            end
        endcase
    end

    // Data for the sampled dot; the dot that wins lock is already shown
    always_comb begin
        lock_now  = (state_nxt == ST_LOCKED);
        smp_h     = frame_start ? 9'd0 : pos_h;
        smp_v     = frame_start ? 9'd0 : pos_v;
        dat_color = BLACK_COLOR;
        dat_emph  = 3'd0;
        if (lock_now) begin
            dat_color = greyscale ? (ppu_color & 6'h30) : ppu_color;
            dat_emph  = ppu_emphasis;
        end
    end

    // Registered stream to the video stage; holds between dots
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color        <= BLACK_COLOR;
            emphasis     <= 3'd0;
            count_h      <= 9'd0;
            count_v      <= 9'd0;
            pix_valid    <= 1'b0;
            locked       <= 1'b0;
            frame_done   <= 1'b0;
            resync_count <= 8'd0;
        end else begin
            pix_valid  <= ce_dot;
            frame_done <= ce_dot && last_dot;
            if (ce_dot) begin
                color    <= dat_color;
                emphasis <= dat_emph;
                count_h  <= smp_h;
                count_v  <= smp_v;
                locked   <= lock_now;
                if (resync_inc && (resync_count != 8'hFF)) begin
                    resync_count <= resync_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_dot_sampler.sv
// tb_ppu_dot_sampler: directed PPU stream against a linear-index frame model.
// Uses a reduced 64x40 raster so lock/relock scenarios stay short.
`timescale 1ns/1ps
module tb_ppu_dot_sampler;

    localparam int H     = 64;
    localparam int V     = 40;
    localparam int F     = H * V;
    localparam int LOCKN = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_dot = 1'b0;
    logic [5:0] ppu_color = 6'd0;
    logic       greyscale = 1'b0;
    logic [2:0] ppu_emphasis = 3'd0;
    logic       frame_start = 1'b0;
    logic       dot_skip = 1'b0;
    logic [5:0] color;
    logic [2:0] emphasis;
    logic [8:0] count_h;
    logic [8:0] count_v;
    logic       pix_valid;
    logic       locked;
    logic       frame_done;
    logic [7:0] resync_count;

    ppu_dot_sampler #(
        .H_TOTAL(H),
        .V_TOTAL(V),
        .LOCK_FRAMES(LOCKN),
        .BLACK_COLOR(6'h0F)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce_dot(ce_dot),
        .ppu_color(ppu_color),
        .greyscale(greyscale),
        .ppu_emphasis(ppu_emphasis),
        .frame_start(frame_start),
        .dot_skip(dot_skip),
        .color(color),
        .emphasis(emphasis),
        .count_h(count_h),
        .count_v(count_v),
        .pix_valid(pix_valid),
        .locked(locked),
        .frame_done(frame_done),
        .resync_count(resync_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: next-dot index in the frame, lock mode 0/1/2, good frames
    int m_idx;
    int m_mode;
    int m_good;
    int m_resync;
    logic [5:0] exp_col;
    logic [2:0] exp_emph;
    logic [8:0] exp_h;
    logic [8:0] exp_v;
    logic       exp_pv;
    logic       exp_locked;
    logic       exp_fd;
    bit         cmp_en = 0;

    task automatic model_reset();
        m_idx = 0;
        m_mode = 0;
        m_good = 0;
        m_resync = 0;
        exp_col = 6'h0F;
        exp_emph = 3'd0;
        exp_h = 9'd0;
        exp_v = 9'd0;
        exp_pv = 1'b0;
        exp_locked = 1'b0;
        exp_fd = 1'b0;
    endtask

    task automatic model_dot(input bit fs, input bit skip,
                             input logic [5:0] col, input bit grey,
                             input logic [2:0] emph);
        int p;
        bit at0;
        bit done;
        at0 = (m_idx == 0);
        done = 0;
        if (fs) begin
            p = 0;
            m_idx = 1;
        end else if (skip && m_idx == F - 2) begin
            p = m_idx;
            m_idx = 0;
            done = 1;
        end else begin
            p = m_idx;
            m_idx = (m_idx + 1) % F;
            done = (p == F - 1);
        end
        if (m_mode == 0) begin
            if (fs) begin
                m_mode = 1;
                m_good = 0;
            end
        end else if (m_mode == 1) begin
            if (fs && at0) begin
                m_good++;
                if (m_good == LOCKN) m_mode = 2;
            end else if (fs || at0) begin
                m_good = 0;
            end
        end else begin
            if (fs != at0) begin
                m_mode = 1;
                m_good = 0;
                if (m_resync < 255) m_resync++;
            end
        end
        exp_pv = 1'b1;
        exp_fd = done;
        exp_h = 9'(p % H);
        exp_v = 9'(p / H);
        exp_locked = (m_mode == 2);
        if (exp_locked) begin
            exp_col = grey ? (col & 6'h30) : col;
            exp_emph = emph;
        end else begin
            exp_col = 6'h0F;
            exp_emph = 3'd0;
        end
    endtask

    // Every cycle: DUT outputs against the model's expectation
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("pix_valid", pix_valid, exp_pv);
            chk("frame_done", frame_done, exp_fd);
            chk("locked", locked, exp_locked);
            chk("color", color, exp_col);
            chk("emphasis", emphasis, exp_emph);
            chk("count_h", count_h, exp_h);
            chk("count_v", count_v, exp_v);
            chk("resync_count", resync_count, m_resync);
        end
    end

    task automatic dot_raw(input bit ce, input bit fs, input bit skip,
                           input logic [5:0] col, input bit grey,
                           input logic [2:0] emph);
        @(negedge clk);
        ce_dot = ce;
        frame_start = fs;
        dot_skip = skip;
        ppu_color = col;
        greyscale = grey;
        ppu_emphasis = emph;
        if (ce) begin
            model_dot(fs, skip, col, grey, emph);
        end else begin
            exp_pv = 1'b0;
            exp_fd = 1'b0;
        end
        @(posedge clk);
    endtask

    // PPU source position and directed overrides
    int         sidx = 0;
    int         gap_ctr = 0;
    bit         suppress = 0;
    bit         ov_en = 0;
    logic [5:0] ov_col = 6'd0;
    bit         ov_grey = 0;
    logic [2:0] ov_emph = 3'd0;

    task automatic ppu_dot(input bit inject, input bit skip_en);
        bit fs;
        bit sk;
        logic [5:0] c;
        bit g;
        logic [2:0] e;
        gap_ctr++;
        if (gap_ctr % 9 == 0) dot_raw(0, 1, 1, 6'h3F, 1, 3'h7);
        fs = inject || (sidx == 0 && !suppress);
        sk = (skip_en && sidx == F - 2) || (sidx == 5);
        c = 6'((sidx * 5 + sidx / H) % 64);
        g = (sidx % 11 == 3);
        e = 3'(sidx % 8);
        if (ov_en) begin
            c = ov_col;
            g = ov_grey;
            e = ov_emph;
            ov_en = 0;
        end
        dot_raw(1, fs, sk, c, g, e);
        if (inject) sidx = 1;
        else if (skip_en && sidx == F - 2) sidx = 0;
        else sidx = (sidx + 1) % F;
    endtask

    task automatic run_to(input int t);
        while (sidx != t) ppu_dot(0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cmp_en = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_color", color, 6'h0F);
        chk("rst_emph", emphasis, 0);
        chk("rst_h", count_h, 0);
        chk("rst_v", count_v, 0);
        chk("rst_pv", pix_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_resync", resync_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // frame 1: first pulse only aligns
        ppu_dot(0, 0);
        #2;
        chk("f1_locked", locked, 0);
        chk("f1_color", color, 6'h0F);
        run_to(0);
        ppu_dot(0, 0);
        run_to(0);
        #2;
        chk("f2_end_fd", frame_done, 1);
        chk("f2_end_h", count_h, 63);
        chk("f2_end_v", count_v, 39);
        chk("f2_end_locked", locked, 0);

        // frame 3 start wins lock, greyscale applies on that dot
        ov_en = 1; ov_col = 6'h2A; ov_grey = 1; ov_emph = 3'd0;
        ppu_dot(0, 0);
        #2;
        chk("lock_locked", locked, 1);
        chk("lock_grey", color, 6'h20);
        chk("lock_h", count_h, 0);
        ov_en = 1; ov_col = 6'h2A; ov_grey = 0; ov_emph = 3'd5;
        ppu_dot(0, 0);
        #2;
        chk("emph_color", color, 6'h2A);
        chk("emph_val", emphasis, 5);
        chk("emph_h", count_h, 1);
        chk("emph_v", count_v, 0);
        chk("emph_resync", resync_count, 0);

        // odd-frame skip
        run_to(F - 2);
        ppu_dot(0, 1);
        #2;
        chk("skip_fd", frame_done, 1);
        chk("skip_h", count_h, 62);
        chk("skip_v", count_v, 39);
        ppu_dot(0, 0);
        #2;
        chk("skip_next_h", count_h, 0);
        chk("skip_next_v", count_v, 0);
        chk("skip_next_locked", locked, 1);

        // spurious frame_start at (50,30)
        run_to(30 * H + 50);
        ppu_dot(1, 0);
        #2;
        chk("inj_h", count_h, 0);
        chk("inj_v", count_v, 0);
        chk("inj_color", color, 6'h0F);
        chk("inj_locked", locked, 0);
        chk("inj_resync", resync_count, 1);
        run_to(0);
        ppu_dot(0, 0);
        #2;
        chk("inj_relock1", locked, 0);
        run_to(0);
        ppu_dot(0, 0);
        #2;
        chk("inj_relock2", locked, 1);

        // one missing frame_start
        run_to(0);
        suppress = 1;
        ppu_dot(0, 0);
        suppress = 0;
        #2;
        chk("miss_locked", locked, 0);
        chk("miss_resync", resync_count, 2);
        chk("miss_color", color, 6'h0F);
        run_to(0);
        ppu_dot(0, 0);
        #2;
        chk("miss_relock1", locked, 0);
        run_to(0);
        ppu_dot(0, 0);
        #2;
        chk("miss_relock2", locked, 1);

        // reset mid-line while locked
        run_to(20 * H + 40);
        @(negedge clk);
        reset_n = 1'b0;
        ce_dot = 1'b0;
        frame_start = 1'b0;
        dot_skip = 1'b0;
        model_reset();
        #1;
        chk("mrst_color", color, 6'h0F);
        chk("mrst_emph", emphasis, 0);
        chk("mrst_h", count_h, 0);
        chk("mrst_v", count_v, 0);
        chk("mrst_pv", pix_valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_resync", resync_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) ppu_dot(0, 0);
        #2;
        chk("free_h", count_h, 4);
        chk("free_v", count_v, 0);
        chk("free_color", color, 6'h0F);
        repeat (2) begin
            run_to(0);
            ppu_dot(0, 0);
            #2;
            chk("post_rst_unlocked", locked, 0);
        end
        run_to(0);
        ppu_dot(0, 0);
        #2;
        chk("post_rst_locked", locked, 1);

        @(negedge clk);
        ce_dot = 1'b0;
        frame_start = 1'b0;
        dot_skip = 1'b0;
        exp_pv = 1'b0;
        exp_fd = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_dot_sampler.md
Name: ppu_dot_sampler

Overview:
- Upstream neighbour of the NES video output stage. It samples the PPU's per-dot pixel output and keeps its own dot-position counters, aligned to PPU frame-start pulses.
- Delivers a clean, registered stream to the video stage: colour index, emphasis bits, count_h and count_v.
- Handles the odd-frame short pre-render line.
- Blanks output to black until the counters are locked to the PPU, so the palette and sync logic downstream never sees garbage positions.

Parameters:
- H_TOTAL, 341, dots per line; positions 0..H_TOTAL-1.
- V_TOTAL, 262, lines per frame; positions 0..V_TOTAL-1.
- LOCK_FRAMES, 2, consecutive matching frame_start pulses required to lock (1..15).
- BLACK_COLOR, 6'h0F, colour index driven while not locked.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ce_dot  in  1  one-clk strobe per PPU dot; all other inputs are sampled only when this is high.
- ppu_color  in  6  PPU palette index for the current dot.
- greyscale  in  1  PPUMASK greyscale bit for the current dot.
- ppu_emphasis  in  3  PPUMASK emphasis bits for the current dot.
- frame_start  in  1  marks the current dot as position (0,0); valid only with ce_dot.
- dot_skip  in  1  odd-frame skip flag; valid only with ce_dot.
- color  out  6  registered colour index to the video stage.
- emphasis  out  3  registered emphasis bits.
- count_h  out  9  horizontal position of the dot on color.
- count_v  out  9  vertical position of the dot on color.
- pix_valid  out  1  one-clk pulse when the outputs update.
- locked  out  1  lock status.
- frame_done  out  1  one-clk pulse coincident with pix_valid for the last dot of a frame.
- resync_count  out  8  saturating count of lock losses since reset.

Behaviour:
- Reset values:
  - color = BLACK_COLOR; emphasis = 0; count_h = 0; count_v = 0.
  - pix_valid = 0; locked = 0; frame_done = 0; resync_count = 0.
  - Internal pos_h = 0, pos_v = 0; state = UNLOCKED; good_cnt = 0.
- pos_h and pos_v always hold the position of the dot being sampled at the next ce_dot.
- Advance on ce_dot:
  - If pos_h == H_TOTAL-1: pos_h = 0, and pos_v increments, wrapping V_TOTAL-1 → 0.
  - Otherwise pos_h increments.
- Odd-frame skip: ce_dot & dot_skip with pos == (H_TOTAL-2, V_TOTAL-1) makes the next position (0,0). dot_skip at any other position is ignored.
- Latency:
  - Outputs register exactly 1 clk after the ce_dot cycle; pix_valid pulses in that same clk.
  - Outputs hold between pix_valid pulses.
- Output data, for the sampled dot at position P:
  - count_h/count_v = P, except when frame_start forced it, in which case (0,0).
  - If locked (including the cycle that achieves lock): color = greyscale ? (ppu_color & 6'h30) : ppu_color, and emphasis = ppu_emphasis.
  - Otherwise: color = BLACK_COLOR and emphasis = 0.
- frame_done fires with pix_valid when P == (H_TOTAL-1, V_TOTAL-1), or when P == (H_TOTAL-2, V_TOTAL-1) and that dot takes the skip.
- State machine (evaluated only on ce_dot):
  - UNLOCKED:
    - frame_start → treat the dot as (0,0), next pos = (1,0), good_cnt = 0, go to ACQUIRE.
    - Otherwise free-run.
  - ACQUIRE:
    - frame_start with pos == (0,0) → good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked = 1 with this dot's output.
    - frame_start elsewhere → realign to (0,0), good_cnt = 0, stay in ACQUIRE.
    - pos == (0,0) without frame_start → good_cnt = 0.
  - LOCKED:
    - frame_start at (0,0) → stay.
    - frame_start elsewhere, or pos == (0,0) without frame_start → realign where frame_start is present, good_cnt = 0, locked = 0, go to ACQUIRE, resync_count++ (saturates at 255).
- frame_start without ce_dot is ignored.
- Simultaneous frame_start and dot_skip: frame_start wins; the dot is (0,0).
- reset_n asserted mid-frame: everything returns to reset values immediately. After release, lock needs LOCK_FRAMES+1 frame_start pulses (the first only aligns).

Test Plan:
- Reset, then 3 frames of 341×262 dots with frame_start each at dot (0,0) → color = 0x0F until the 3rd frame_start dot; locked rises 1 clk after that ce_dot; resync_count = 0.
- Locked; ppu_color = 0x2A with greyscale = 1 → color = 0x20. With greyscale = 0 and ppu_emphasis = 3'b101 → color = 0x2A, emphasis = 5, count_h/count_v track the dot 1 clk later.
- Locked; dot_skip at (339,261) → frame_done pulses on that dot; next output (0,0); lock is held when frame_start arrives there.
- Locked; frame_start injected at (100,50) → that dot outputs (0,0) with color 0x0F; locked = 0; resync_count = 1; relock after 2 further matching frames.
- Locked; frame_start suppressed for one frame → at (0,0) locked drops and resync_count increments; next frame_start at (0,0) counts toward relock.
- Assert reset_n low mid-line at (200,100) while locked → all outputs return to reset values in the same cycle; the counters free-run from (0,0) after release.
